lstm_x_loader: RTL
==================

// Module: lstm_x_loader
// PURPOSE
//  Double-buffered input-sequence loader upstream of layer-1 LSTM forward pass.
//  Accepts a valid/ready stream of x samples, one sequence = TIMESTEP*NUM_INPUT words.
//  Stores each sequence in one of two banks, then pulses start to the LSTM control FSM.
//  Serves layer-1 x reads (addr_gen_fwd_x address) from the active bank while the other bank fills.
// PARAMETERS
//  WIDTH      24   sample width, signed fixed point (FRAC=16), passed through unmodified
//  ADDR_WIDTH 12   read address width
//  TIMESTEP   7    timesteps per sequence
//  NUM_INPUT  53   layer-1 inputs per timestep
//  DEPTH      TIMESTEP*NUM_INPUT (371), derived localparam, words per bank
// PORTS
//  clk        in   1           single clock
//  rst        in   1           synchronous reset, active-high
//  s_valid    in   1           input word valid
//  s_data     in   WIDTH       input word, timestep-major order (t0 x0..x52, t1 x0..)
//  s_last     in   1           marks final word of a sequence
//  s_ready    out  1           loader can accept s_data this cycle
//  rd_addr    in   ADDR_WIDTH  x read address within active bank (0..DEPTH-1)
//  rd_data    out  WIDTH       x word, registered
//  seq_ready  out  1           active (read) bank holds a complete sequence
//  start      out  1           one-cycle pulse: sequence available, LSTM may begin
//  done       in   1           one-cycle pulse from FSM: active bank consumed, release it
//  err_len    out  1           sticky: s_last framing violation seen
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): s_ready=0, start=0, seq_ready=0, err_len=0, rd_data=0,
//   full[1:0]=0, wr_bank=0, rd_bank=0, wr_cnt=0, read FSM=IDLE. RAM contents not cleared.
//   Reset mid-sequence discards partial and complete banks. s_ready=1 from first cycle after rst=0.
//  Write side: s_ready = ~full[wr_bank]. Transfer = s_valid & s_ready.
//   Each transfer writes RAM[{wr_bank, wr_cnt}], wr_cnt++.
//   Transfer with wr_cnt==DEPTH-1: commit -> full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
//    If s_last=0 on that word: commit anyway, err_len<=1.
//   Transfer with s_last=1 and wr_cnt<DEPTH-1: early end -> err_len<=1, wr_cnt<=0,
//    bank stays empty (partial sequence dropped), wr_bank unchanged.
//   Both banks full: s_ready=0; upstream holds s_data (standard valid/ready, no drop).
//  Read FSM (states IDLE, RUN):
//   IDLE: if full[rd_bank] -> start=1 for one cycle, go RUN; else stay.
//   RUN : on done=1 -> full[rd_bank]<=0, rd_bank toggles, go IDLE. done in IDLE ignored.
//   A full bank waiting in IDLE starts one cycle after release: done@N -> IDLE@N+1 -> start@N+1.
//  seq_ready = full[rd_bank] (combinational from registers).
//  Simultaneous commit and release in one cycle: always different banks; both take effect.
//   If writer was blocked on the released bank, s_ready rises the following cycle.
//  Read: rd_data <= RAM[{rd_bank, rd_addr}], 1-cycle latency, every cycle regardless of state.
//   rd_addr >= DEPTH, or MSB set (negative from signed generator): rd_data <= 0.
//  No arithmetic on data; widths preserved bit-exact.
// STRUCTURE
//  Shared include lstm_params.vh: WIDTH, FRAC, TIMESTEP, LAYR1_INPUT, ADDR_WIDTH defaults;
//   loader FSM state encodings (LDR_IDLE=0, LDR_RUN=1).
//  One sub-module: x_bank_ram, 2*DEPTH x WIDTH simple dual-port RAM,
//   1 write port, 1 registered read port, address {bank, offset}, no reset on contents.
//  Control (counters, full flags, read FSM, range check) stays in lstm_x_loader.
// TESTING
//  1. Stream 371 words 0..370 with s_last on word 370 -> start pulse 1 cycle later (IDLE detect);
//     rd_addr=5 -> rd_data=5 next cycle; rd_addr=371 -> rd_data=0; err_len=0.
//  2. Load 3 sequences back-to-back, no done -> 2 accepted, s_ready=0 on 1st word of 3rd;
//     pulse done -> s_ready=1 next cycle, 2nd start same cycle as IDLE re-entry, reads seq 2.
//  3. s_last on word 100 -> err_len=1, no start; next clean 371-word sequence -> start,
//     rd_addr=0 returns its first word (partial data not visible).
//  4. 371 words without s_last -> sequence committed, start pulses, err_len=1 sticky.
//  5. rst asserted mid-fill (word 200) with one bank full -> all outputs at reset values,
//     seq_ready=0; next full sequence lands in bank 0 and starts normally.
//  6. Random s_valid gaps and done timing vs reference queue model -> every rd_data matches, no loss.

Source files
------------

// File: rtl/lstm_x_loader_pkg.sv
// Shared defaults and types for the layer-1 LSTM x-sequence loader.
// The sub-module, the loader top and the bench all import these.
package lstm_x_loader_pkg;

    localparam int DEF_WIDTH      = 24;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_TIMESTEP   = 7;
    localparam int DEF_NUM_INPUT  = 53;

    typedef enum logic {
        LDR_IDLE = 1'b0,
        LDR_RUN  = 1'b1
    } ldr_state_e;

endpackage

// File: rtl/x_bank_ram.sv
// Two-bank simple dual-port sample store: one write port, one registered read port.
// The read port has a synchronous clear that forces the output word to zero.
module x_bank_ram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 371,
    parameter int OFF_W = 9
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_clr,
    input  logic             rd_bank,
    input  logic [OFF_W-1:0] rd_off,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2][DEPTH];

    // NOTE: the array has no reset. Clearing it would need a per-word reset
    // tree, and it gains nothing because a bank is only read once it is full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_off] <= wr_data;
        end
        if (rd_clr) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_bank][rd_off];
        end
    end

endmodule

// File: rtl/lstm_x_loader.sv
// Double-buffered x-sequence loader: fills one bank from a valid/ready stream
// while the LSTM reads the other bank, and hands off complete banks with start/done.
module lstm_x_loader
    import lstm_x_loader_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMESTEP   = DEF_TIMESTEP,
    parameter int NUM_INPUT  = DEF_NUM_INPUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  seq_ready,
    output logic                  start,
    input  logic                  done,
    output logic                  err_len
);

    localparam int DEPTH = TIMESTEP * NUM_INPUT;
    localparam int OFF_W = $clog2(DEPTH);
    localparam logic [OFF_W-1:0]      LAST_OFF = OFF_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] RD_LIMIT = ADDR_WIDTH'(DEPTH);

    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [OFF_W-1:0] wr_cnt;
    ldr_state_e       state;
    ldr_state_e       state_next;

    logic             xfer;
    logic             commit;
    logic             early_end;
    logic             release_bank;
    logic             rd_in_range;
    logic [OFF_W-1:0] rd_off;

    // The reset term keeps s_ready low for every cycle rst is high.
    assign s_ready   = ~rst & ~full[wr_bank];
    assign xfer      = s_valid & s_ready;
    assign commit    = xfer & (wr_cnt == LAST_OFF);
    assign early_end = xfer & s_last & (wr_cnt != LAST_OFF);
    assign seq_ready = full[rd_bank];

    always_comb begin
        // NOTE: every output of this block gets a default before the case.
        // A path that leaves one unassigned would infer a latch.
        state_next   = state;
        start        = 1'b0;
        release_bank = 1'b0;
        case (state)
            LDR_IDLE: begin
                if (full[rd_bank]) begin
                    start      = 1'b1;
                    state_next = LDR_RUN;
                end
            end
            LDR_RUN: begin
                if (done) begin
                    release_bank = 1'b1;
                    state_next   = LDR_IDLE;
                end
            end
            default: state_next = LDR_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments. A release and a commit
    // in the same cycle change different bits of full, so both updates land.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LDR_IDLE;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            err_len <= 1'b0;
        end else begin
            state <= state_next;
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (commit) begin
                // A full-length sequence is kept even if s_last is missing.
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
                wr_cnt        <= '0;
                if (!s_last) begin
                    err_len <= 1'b1;
                end
            end else if (early_end) begin
                wr_cnt  <= '0;
                err_len <= 1'b1;
            end else if (xfer) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Addresses with the MSB set come from the signed generator; they read as zero.
    assign rd_in_range = ~rd_addr[ADDR_WIDTH-1] & (rd_addr < RD_LIMIT);
    assign rd_off      = rd_in_range ? rd_addr[OFF_W-1:0] : '0;

    x_bank_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .OFF_W (OFF_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (xfer),
        .wr_bank (wr_bank),
        .wr_off  (wr_cnt),
        .wr_data (s_data),
        .rd_clr  (rst | ~rd_in_range),
        .rd_bank (rd_bank),
        .rd_off  (rd_off),
        .rd_data (rd_data)
    );

endmodule
